// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_arb_pkg: shared FSM state encoding and read/write encoding for the data-cache port arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way winner select, round-robin or fixed priority to requester 0
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       fixed_pri_i,
    output logic       win_o
);

    // A lone requester wins; on contention either 0 wins outright or the one not served last wins
    always_comb begin
        win_o = (req_i == 2'b10) ? 1'b1 :
                (req_i == 2'b11) ? (fixed_pri_i ? 1'b0 : ~last_i) : 1'b0;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-cache port between the stage-1 controller (0) and the I/O engine (1)
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int DEPTH     = 8,
    parameter int HIT_LAT   = 1,
    parameter int MISS_LAT  = 4,
    parameter int FIXED_PRI = 0
) (
    input  logic          g_clk,
    input  logic          g_clr,
    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          done0,
    output logic          err0,
    output logic [DW-1:0] rdata0,
    output logic          gnt1,
    output logic          done1,
    output logic          err1,
    output logic [DW-1:0] rdata1,
    output logic          ch_en,
    output logic          ch_rw,
    output logic [AW-1:0] ch_addr,
    output logic [DW-1:0] ch_wdata,
    input  logic [DW-1:0] ch_rdata,
    input  logic          ch_hit,
    output logic          busy,
    output logic          owner
);

    localparam int            CW      = $clog2(MISS_LAT + 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    state_t        state_q;
    logic          owner_q;
    logic          last_q;
    logic          rw_q;
    logic          err_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic [CW-1:0] cnt_q;

    logic          win;
    logic          rw_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic          err_d;
    logic [CW-1:0] cnt_d;

    rr_pick2 u_pick (
        .req_i       ({req1, req0}),
        .last_i      (last_q),
        .fixed_pri_i (FIXED_PRI != 0),
        .win_o       (win)
    );

    // Winner's request fields, range check, and the wait length chosen by the hit flag
    always_comb begin
        rw_d    = win ? rw1 : rw0;
        addr_d  = win ? addr1 : addr0;
        wdata_d = win ? wdata1 : wdata0;
        err_d   = {1'b0, addr_d} >= DEPTH_W;
        cnt_d   = ch_hit ? CW'(HIT_LAT - 1) : CW'(MISS_LAT - 1);
    end

    // Access sequencer: latch in IDLE, strobe the cache in ISSUE, count in WAIT, report in DONE
    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            rw_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner_q <= win;
                        rw_q    <= rw_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        err_q   <= err_d;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= cnt_d;
                    state_q <= err_q ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        if (rw_q == RW_READ && !owner_q) rdata0_q <= ch_rdata;
                        if (rw_q == RW_READ && owner_q) rdata1_q <= ch_rdata;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    last_q  <= owner_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake strobes decoded purely from registered state so no request reaches them combinationally
    always_comb begin
        gnt0     = (state_q == ST_ISSUE) && !owner_q;
        gnt1     = (state_q == ST_ISSUE) && owner_q;
        done0    = (state_q == ST_DONE) && !owner_q;
        done1    = (state_q == ST_DONE) && owner_q;
        err0     = done0 && err_q;
        err1     = done1 && err_q;
        ch_en    = (state_q == ST_ISSUE) && !err_q;
        ch_rw    = rw_q;
        ch_addr  = addr_q;
        ch_wdata = wdata_q;
        rdata0   = rdata0_q;
        rdata1   = rdata1_q;
        busy     = state_q != ST_IDLE;
        owner    = owner_q;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of the port arbiter in round-robin and fixed-priority builds
module tb_dmem_port_arbiter;

    logic       g_clk = 1'b0;
    logic       g_clr = 1'b0;
    logic       req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [7:0] ch_rdata = '0;
    logic       ch_hit = 1'b0;

    logic       gnt0, done0, err0, gnt1, done1, err1, ch_en, ch_rw, busy, owner;
    logic [7:0] rdata0, rdata1, ch_addr, ch_wdata;

    logic       f_gnt0, f_done0, f_err0, f_gnt1, f_done1, f_err1, f_ch_en, f_ch_rw, f_busy, f_owner;
    logic [7:0] f_rdata0, f_rdata1, f_ch_addr, f_ch_wdata;

    int n_pass = 0;
    int n_total = 0;

    always #5 g_clk = ~g_clk;

    dmem_port_arbiter u_rr (
        .g_clk(g_clk), .g_clr(g_clr),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
        .ch_en(ch_en), .ch_rw(ch_rw), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_rdata(ch_rdata), .ch_hit(ch_hit), .busy(busy), .owner(owner)
    );

    dmem_port_arbiter #(.FIXED_PRI(1)) u_fp (
        .g_clk(g_clk), .g_clr(g_clr),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(f_gnt0), .done0(f_done0), .err0(f_err0), .rdata0(f_rdata0),
        .gnt1(f_gnt1), .done1(f_done1), .err1(f_err1), .rdata1(f_rdata1),
        .ch_en(f_ch_en), .ch_rw(f_ch_rw), .ch_addr(f_ch_addr), .ch_wdata(f_ch_wdata),
        .ch_rdata(ch_rdata), .ch_hit(ch_hit), .busy(f_busy), .owner(f_owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge g_clk);
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_ch_en", ch_en, 0);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_owner", owner, 0);
        chk("rst_ch_addr", ch_addr, 0);
        chk("rst_rdata0", rdata0, 0);
        g_clr = 1'b1;
        tick();

        // 1: read hit from requester 0
        req0 = 1; rw0 = 0; addr0 = 8'd3; ch_hit = 1; ch_rdata = 8'hA5;
        tick();
        chk("t1_gnt0_c1", gnt0, 1);
        chk("t1_ch_en_c1", ch_en, 1);
        chk("t1_ch_addr_c1", ch_addr, 3);
        chk("t1_ch_rw_c1", ch_rw, 0);
        req0 = 0;
        tick();
        chk("t1_ch_en_c2", ch_en, 0);
        chk("t1_gnt0_c2", gnt0, 0);
        chk("t1_done0_c2", done0, 0);
        chk("t1_busy_c2", busy, 1);
        tick();
        chk("t1_done0_c3", done0, 1);
        chk("t1_err0_c3", err0, 0);
        chk("t1_rdata0_c3", rdata0, 8'hA5);
        ch_rdata = 8'h11;
        tick();
        chk("t1_done0_c4", done0, 0);
        chk("t1_busy_c4", busy, 0);
        chk("t1_rdata0_hold", rdata0, 8'hA5);

        // 2: write miss from requester 1
        req1 = 1; rw1 = 1; addr1 = 8'd5; wdata1 = 8'h3C; ch_hit = 0;
        tick();
        chk("t2_gnt1_c1", gnt1, 1);
        chk("t2_ch_en_c1", ch_en, 1);
        chk("t2_ch_rw_c1", ch_rw, 1);
        chk("t2_ch_wdata_c1", ch_wdata, 8'h3C);
        chk("t2_owner_c1", owner, 1);
        req1 = 0; wdata1 = 8'hFF; addr1 = 8'd7;
        tick(); tick(); tick(); tick();
        chk("t2_ch_wdata_c5", ch_wdata, 8'h3C);
        chk("t2_ch_addr_c5", ch_addr, 5);
        chk("t2_ch_rw_c5", ch_rw, 1);
        chk("t2_ch_en_c5", ch_en, 0);
        chk("t2_done1_c5", done1, 0);
        tick();
        chk("t2_done1_c6", done1, 1);
        chk("t2_err1_c6", err1, 0);
        chk("t2_rdata1_c6", rdata1, 0);
        tick();
        chk("t2_busy_c7", busy, 0);

        // 4: out-of-range address
        req0 = 1; rw0 = 0; addr0 = 8'd8; ch_hit = 1;
        tick();
        chk("t4_gnt0_c1", gnt0, 1);
        chk("t4_ch_en_c1", ch_en, 0);
        req0 = 0;
        tick();
        chk("t4_done0_c2", done0, 1);
        chk("t4_err0_c2", err0, 1);
        chk("t4_rdata0_c2", rdata0, 8'hA5);
        tick();
        chk("t4_done0_c3", done0, 0);
        chk("t4_busy_c3", busy, 0);

        // 6: one-cycle req1 pulse during a req0 miss
        req0 = 1; rw0 = 0; addr0 = 8'd2; ch_hit = 0; ch_rdata = 8'h5A;
        tick();
        chk("t6_gnt0_c1", gnt0, 1);
        req0 = 0;
        tick();
        req1 = 1; rw1 = 0; addr1 = 8'd1;
        tick();
        req1 = 0;
        chk("t6_gnt1_c3", gnt1, 0);
        tick(); tick();
        chk("t6_gnt1_c5", gnt1, 0);
        chk("t6_done0_c5", done0, 0);
        tick();
        chk("t6_done0_c6", done0, 1);
        chk("t6_rdata0_c6", rdata0, 8'h5A);
        chk("t6_gnt1_c6", gnt1, 0);
        tick();
        chk("t6_gnt1_c7", gnt1, 0);
        tick();
        chk("t6_gnt1_c8", gnt1, 0);
        chk("t6_busy_c8", busy, 0);

        // 5: async reset during the wait of a miss
        req0 = 1; rw0 = 0; addr0 = 8'd4; ch_hit = 0;
        tick();
        chk("t5_gnt0_c1", gnt0, 1);
        req0 = 0;
        tick();
        chk("t5_busy_c2", busy, 1);
        g_clr = 1'b0;
        #1;
        chk("t5_busy_rst", busy, 0);
        chk("t5_ch_en_rst", ch_en, 0);
        chk("t5_gnt0_rst", gnt0, 0);
        chk("t5_rdata0_rst", rdata0, 0);
        tick();
        chk("t5_done0_rst", done0, 0);
        g_clr = 1'b1;
        tick();
        chk("t5_done0_post", done0, 0);
        chk("t5_busy_post", busy, 0);
        req1 = 1; rw1 = 0; addr1 = 8'd6; ch_hit = 1; ch_rdata = 8'hC3;
        tick();
        chk("t5_gnt1_c1", gnt1, 1);
        chk("t5_owner_c1", owner, 1);
        req1 = 0;
        tick(); tick();
        chk("t5_done1_c3", done1, 1);
        chk("t5_rdata1_c3", rdata1, 8'hC3);
        tick();

        // 3: both requesting continuously
        req0 = 1; req1 = 1; rw0 = 0; rw1 = 0; addr0 = 8'd1; addr1 = 8'd2; ch_hit = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("t3_rr_gnt0", gnt0, (k % 4 == 1) && (((k - 1) / 4) % 2 == 0));
            chk("t3_rr_gnt1", gnt1, (k % 4 == 1) && (((k - 1) / 4) % 2 == 1));
            chk("t3_fp_gnt0", f_gnt0, k % 4 == 1);
            chk("t3_fp_gnt1", f_gnt1, 0);
            if (k == 16) begin
                req0 = 0;
                req1 = 0;
            end
        end
        tick();
        chk("t3_rr_busy_end", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
